// File: rtl/debug_step_controller_pkg.sv
// Shared constants for the debug step controller: host command codes and controller state encodings.
package debug_step_controller_pkg;

    localparam logic [1:0] DBG_CMD_NOP  = 2'b00;
    localparam logic [1:0] DBG_CMD_HALT = 2'b01;
    localparam logic [1:0] DBG_CMD_RUN  = 2'b10;
    localparam logic [1:0] DBG_CMD_STEP = 2'b11;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_HALTING  = 3'd1,
        ST_HALTED   = 3'd2,
        ST_STEP_REQ = 3'd3,
        ST_STEP_REL = 3'd4
    } dbg_state_e;

    // States where the controller is waiting on a decoder edge and the timeout runs.
    function automatic logic is_waiting(input dbg_state_e s);
        return (s == ST_HALTING) || (s == ST_STEP_REQ) || (s == ST_STEP_REL);
    endfunction

endpackage

// File: rtl/dbg_timeout_timer.sv
// Cycle counter for handshake timeouts: cleared on state change, counts while enabled,
// flags the cycle on which LIMIT waiting cycles have elapsed.
module dbg_timeout_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = enable && !clear && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/debug_step_controller.sv
// Host-side debug master: turns HALT/RUN/STEP commands into the decoder's stop level and
// 4-phase step handshake, with a single PC breakpoint and a handshake timeout.
module debug_step_controller
    import debug_step_controller_pkg::*;
#(
    parameter int COUNT_W      = 8,
    parameter int TIMEOUT_CYC  = 64,
    parameter bit START_HALTED = 1'b0
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               CMD_VALID,
    input  logic [1:0]         CMD,
    input  logic [COUNT_W-1:0] CMD_COUNT,
    output logic               CMD_READY,
    input  logic               BP_ENABLE,
    input  logic [15:0]        BP_ADDR,
    input  logic [15:0]        PC,
    input  logic               DECODE,
    input  logic               STOPPED,
    input  logic               DEBUG_STEP_ACK,
    output logic               DEBUG_STOPX,
    output logic               DEBUG_STEP_REQ,
    output logic [COUNT_W-1:0] STEPS_REMAINING,
    output logic               BP_HIT,
    output logic               DONE,
    output logic               ERROR,
    output dbg_state_e         dbg_state
);

    dbg_state_e state;
    logic       timer_clear;
    logic       timer_tc;
    logic       cmd_fire;
    logic       bp_match;
    logic       run_go_halting;

    assign cmd_fire       = CMD_VALID && CMD_READY;
    assign bp_match       = BP_ENABLE && DECODE && (PC == BP_ADDR);
    assign run_go_halting = bp_match ||
                            (cmd_fire && ((CMD == DBG_CMD_HALT) || (CMD == DBG_CMD_STEP)));
    assign dbg_state      = state;

    dbg_timeout_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk    (CLK),
        .rst_n  (RESETN),
        .clear  (timer_clear),
        .enable (is_waiting(state)),
        .tc     (timer_tc)
    );

    // Valid/ready: a command is taken on a cycle where CMD_VALID and CMD_READY are both high;
    // READY is registered and high only in RUN and HALTED, otherwise commands are dropped.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state           <= START_HALTED ? ST_HALTING : ST_RUN;
            CMD_READY       <= !START_HALTED;
            DEBUG_STOPX     <= START_HALTED;
            DEBUG_STEP_REQ  <= 1'b0;
            STEPS_REMAINING <= '0;
            BP_HIT          <= 1'b0;
            DONE            <= 1'b0;
            ERROR           <= 1'b0;
            timer_clear     <= 1'b0;
        end else begin
            DONE        <= 1'b0;
            timer_clear <= 1'b0;
            unique case (state)
                ST_RUN: begin
                    if (cmd_fire && (CMD == DBG_CMD_RUN)) BP_HIT <= 1'b0;
                    if (cmd_fire && (CMD == DBG_CMD_STEP)) STEPS_REMAINING <= CMD_COUNT;
                    // Stop is raised in the cycle after DECODE so the matching instruction still commits.
                    if (bp_match) BP_HIT <= 1'b1;
                    if (run_go_halting) begin
                        DEBUG_STOPX <= 1'b1;
                        CMD_READY   <= 1'b0;
                        timer_clear <= 1'b1;
                        state       <= ST_HALTING;
                    end
                end
                ST_HALTING: begin
                    if (STOPPED) begin
                        timer_clear <= 1'b1;
                        if (STEPS_REMAINING != '0) begin
                            DEBUG_STEP_REQ <= 1'b1;
                            state          <= ST_STEP_REQ;
                        end else begin
                            DONE      <= 1'b1;
                            CMD_READY <= 1'b1;
                            state     <= ST_HALTED;
                        end
                    end else if (timer_tc) begin
                        ERROR           <= 1'b1;
                        STEPS_REMAINING <= '0;
                        CMD_READY       <= 1'b1;
                        timer_clear     <= 1'b1;
                        state           <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (cmd_fire) begin
                        case (CMD)
                            DBG_CMD_RUN: begin
                                DEBUG_STOPX <= 1'b0;
                                BP_HIT      <= 1'b0;
                                state       <= ST_RUN;
                            end
                            DBG_CMD_HALT: DONE <= 1'b1;
                            DBG_CMD_STEP: begin
                                if (CMD_COUNT == '0) begin
                                    DONE <= 1'b1;
                                end else begin
                                    STEPS_REMAINING <= CMD_COUNT;
                                    DEBUG_STEP_REQ  <= 1'b1;
                                    CMD_READY       <= 1'b0;
                                    timer_clear     <= 1'b1;
                                    state           <= ST_STEP_REQ;
                                end
                            end
                            DBG_CMD_NOP: ;
                            default: ;
                        endcase
                    end
                end
                ST_STEP_REQ: begin
                    if (DEBUG_STEP_ACK) begin
                        DEBUG_STEP_REQ  <= 1'b0;
                        STEPS_REMAINING <= STEPS_REMAINING - COUNT_W'(1);
                        timer_clear     <= 1'b1;
                        state           <= ST_STEP_REL;
                    end else if (timer_tc) begin
                        ERROR           <= 1'b1;
                        DEBUG_STEP_REQ  <= 1'b0;
                        STEPS_REMAINING <= '0;
                        CMD_READY       <= 1'b1;
                        timer_clear     <= 1'b1;
                        state           <= ST_HALTED;
                    end
                end
                ST_STEP_REL: begin
                    if (!DEBUG_STEP_ACK) begin
                        timer_clear <= 1'b1;
                        if (STEPS_REMAINING == '0) begin
                            DONE      <= 1'b1;
                            CMD_READY <= 1'b1;
                            state     <= ST_HALTED;
                        end else begin
                            DEBUG_STEP_REQ <= 1'b1;
                            state          <= ST_STEP_REQ;
                        end
                    end else if (timer_tc) begin
                        ERROR           <= 1'b1;
                        STEPS_REMAINING <= '0;
                        CMD_READY       <= 1'b1;
                        timer_clear     <= 1'b1;
                        state           <= ST_HALTED;
                    end
                end
                default: begin
                    DEBUG_STOPX    <= 1'b1;
                    DEBUG_STEP_REQ <= 1'b0;
                    CMD_READY      <= 1'b1;
                    state          <= ST_HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_step_controller.sv
// Directed bench for debug_step_controller: a hand-driven decoder model with a step-count scoreboard.
module tb_debug_step_controller;
  import debug_step_controller_pkg::*;

  localparam int COUNT_W = 8;
  localparam int TIMEOUT_CYC = 64;

  logic CLK;
  logic RESETN;
  logic CMD_VALID;
  logic [1:0] CMD;
  logic [COUNT_W-1:0] CMD_COUNT;
  logic CMD_READY;
  logic BP_ENABLE;
  logic [15:0] BP_ADDR;
  logic [15:0] PC;
  logic DECODE;
  logic STOPPED;
  logic DEBUG_STEP_ACK;
  logic DEBUG_STOPX;
  logic DEBUG_STEP_REQ;
  logic [COUNT_W-1:0] STEPS_REMAINING;
  logic BP_HIT;
  logic DONE;
  logic ERROR;
  dbg_state_e dbg_state;

  int total;
  int bad;
  int done_cnt;
  int n;
  logic [COUNT_W-1:0] exp_q[$];

  debug_step_controller #(
    .COUNT_W(COUNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .START_HALTED(1'b0)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .CMD_VALID(CMD_VALID),
    .CMD(CMD),
    .CMD_COUNT(CMD_COUNT),
    .CMD_READY(CMD_READY),
    .BP_ENABLE(BP_ENABLE),
    .BP_ADDR(BP_ADDR),
    .PC(PC),
    .DECODE(DECODE),
    .STOPPED(STOPPED),
    .DEBUG_STEP_ACK(DEBUG_STEP_ACK),
    .DEBUG_STOPX(DEBUG_STOPX),
    .DEBUG_STEP_REQ(DEBUG_STEP_REQ),
    .STEPS_REMAINING(STEPS_REMAINING),
    .BP_HIT(BP_HIT),
    .DONE(DONE),
    .ERROR(ERROR),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
    if (DONE) done_cnt++;
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [COUNT_W-1:0] cnt);
    CMD_VALID = 1'b1;
    CMD = c;
    CMD_COUNT = cnt;
    tick();
    CMD_VALID = 1'b0;
    CMD = DBG_CMD_NOP;
    CMD_COUNT = '0;
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int k;
    k = 0;
    while (DEBUG_STEP_REQ !== lvl && k < 50) begin
      tick();
      k++;
    end
    check(tag, 16'(DEBUG_STEP_REQ), 16'(lvl));
  endtask

  initial begin
    total = 0;
    bad = 0;
    done_cnt = 0;
    RESETN = 1'b0;
    CMD_VALID = 1'b0;
    CMD = DBG_CMD_NOP;
    CMD_COUNT = '0;
    BP_ENABLE = 1'b0;
    BP_ADDR = 16'h0000;
    PC = 16'h0000;
    DECODE = 1'b0;
    STOPPED = 1'b0;
    DEBUG_STEP_ACK = 1'b0;

    // reset values
    #12;
    check("rst_stopx", 16'(DEBUG_STOPX), 16'd0);
    check("rst_req", 16'(DEBUG_STEP_REQ), 16'd0);
    check("rst_steps", 16'(STEPS_REMAINING), 16'd0);
    check("rst_bphit", 16'(BP_HIT), 16'd0);
    check("rst_done", 16'(DONE), 16'd0);
    check("rst_error", 16'(ERROR), 16'd0);
    check("rst_ready", 16'(CMD_READY), 16'd1);
    check("rst_state", 16'(dbg_state), 16'(ST_RUN));
    tick();
    RESETN = 1'b1;

    // idle in RUN
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_stopx", 16'(DEBUG_STOPX), 16'd0);
      check("idle_ready", 16'(CMD_READY), 16'd1);
    end

    // HALT from RUN, decoder stops after 4 cycles
    done_cnt = 0;
    send_cmd(DBG_CMD_HALT, '0);
    check("halt_stopx", 16'(DEBUG_STOPX), 16'd1);
    check("halt_ready", 16'(CMD_READY), 16'd0);
    check("halt_state", 16'(dbg_state), 16'(ST_HALTING));
    tick();
    tick();
    tick();
    STOPPED = 1'b1;
    tick();
    check("halt_done", 16'(DONE), 16'd1);
    check("halt_halted", 16'(dbg_state), 16'(ST_HALTED));
    check("halt_ready2", 16'(CMD_READY), 16'd1);
    tick();
    check("halt_done_pulse", 16'(DONE), 16'd0);
    check("halt_done_cnt", 16'(done_cnt), 16'd1);

    // STEP 3 from HALTED
    done_cnt = 0;
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd0);
    send_cmd(DBG_CMD_STEP, 8'd3);
    wait_req(1'b1, "step_req_first");
    check("step_cnt_start", 16'(STEPS_REMAINING), 16'(exp_q.pop_front()));
    for (int i = 0; i < 3; i++) begin
      wait_req(1'b1, "step_req_hi");
      check("step_stopx", 16'(DEBUG_STOPX), 16'd1);
      DEBUG_STEP_ACK = 1'b1;
      tick();
      check("step_req_lo", 16'(DEBUG_STEP_REQ), 16'd0);
      check("step_cnt", 16'(STEPS_REMAINING), 16'(exp_q.pop_front()));
      DEBUG_STEP_ACK = 1'b0;
      tick();
    end
    check("step_halted", 16'(dbg_state), 16'(ST_HALTED));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("step_no_extra_req", 16'(DEBUG_STEP_REQ), 16'd0);
    end
    check("step_done_cnt", 16'(done_cnt), 16'd1);
    check("step_q_empty", 16'(exp_q.size()), 16'd0);

    // HALT and STEP 0 while HALTED each pulse DONE
    send_cmd(DBG_CMD_HALT, '0);
    check("halted_halt_done", 16'(DONE), 16'd1);
    check("halted_halt_state", 16'(dbg_state), 16'(ST_HALTED));
    send_cmd(DBG_CMD_STEP, 8'd0);
    check("step0_done", 16'(DONE), 16'd1);
    check("step0_req", 16'(DEBUG_STEP_REQ), 16'd0);
    check("step0_state", 16'(dbg_state), 16'(ST_HALTED));

    // breakpoint at 0x0040
    send_cmd(DBG_CMD_RUN, '0);
    check("run_stopx", 16'(DEBUG_STOPX), 16'd0);
    check("run_state", 16'(dbg_state), 16'(ST_RUN));
    STOPPED = 1'b0;
    BP_ENABLE = 1'b1;
    BP_ADDR = 16'h0040;
    PC = 16'h0040;
    DECODE = 1'b0;
    tick();
    check("bp_nodecode_stopx", 16'(DEBUG_STOPX), 16'd0);
    PC = 16'h003E;
    DECODE = 1'b1;
    tick();
    check("bp_3e_stopx", 16'(DEBUG_STOPX), 16'd0);
    check("bp_3e_hit", 16'(BP_HIT), 16'd0);
    PC = 16'h0040;
    tick();
    check("bp_40_stopx", 16'(DEBUG_STOPX), 16'd1);
    check("bp_40_hit", 16'(BP_HIT), 16'd1);
    check("bp_40_state", 16'(dbg_state), 16'(ST_HALTING));
    DECODE = 1'b0;
    PC = 16'h0042;
    tick();
    done_cnt = 0;
    STOPPED = 1'b1;
    tick();
    check("bp_halted", 16'(dbg_state), 16'(ST_HALTED));
    check("bp_done_cnt", 16'(done_cnt), 16'd1);
    check("bp_hit_sticky", 16'(BP_HIT), 16'd1);
    BP_ENABLE = 1'b0;

    // STEP 2 with ACK stuck low -> timeout
    send_cmd(DBG_CMD_STEP, 8'd2);
    check("to_req", 16'(DEBUG_STEP_REQ), 16'd1);
    n = 0;
    while (ERROR !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("to_error", 16'(ERROR), 16'd1);
    check("to_window", 16'((n >= TIMEOUT_CYC) && (n <= TIMEOUT_CYC + 2)), 16'd1);
    check("to_req_lo", 16'(DEBUG_STEP_REQ), 16'd0);
    check("to_steps", 16'(STEPS_REMAINING), 16'd0);
    check("to_ready", 16'(CMD_READY), 16'd1);
    check("to_state", 16'(dbg_state), 16'(ST_HALTED));
    check("to_stopx", 16'(DEBUG_STOPX), 16'd1);

    // RUN clears BP_HIT, ERROR stays sticky
    send_cmd(DBG_CMD_RUN, '0);
    check("run2_bphit", 16'(BP_HIT), 16'd0);
    check("run2_error", 16'(ERROR), 16'd1);
    check("run2_stopx", 16'(DEBUG_STOPX), 16'd0);
    STOPPED = 1'b0;

    // STEP 1 from RUN, ignored RUN while busy, then reset mid-handshake
    send_cmd(DBG_CMD_STEP, 8'd1);
    check("s1_halting", 16'(dbg_state), 16'(ST_HALTING));
    STOPPED = 1'b1;
    tick();
    check("s1_req", 16'(DEBUG_STEP_REQ), 16'd1);
    check("s1_steps", 16'(STEPS_REMAINING), 16'd1);
    send_cmd(DBG_CMD_RUN, '0);
    check("busy_state", 16'(dbg_state), 16'(ST_STEP_REQ));
    check("busy_stopx", 16'(DEBUG_STOPX), 16'd1);
    check("busy_req", 16'(DEBUG_STEP_REQ), 16'd1);
    check("busy_ready", 16'(CMD_READY), 16'd0);
    RESETN = 1'b0;
    #1;
    check("mid_rst_req", 16'(DEBUG_STEP_REQ), 16'd0);
    check("mid_rst_stopx", 16'(DEBUG_STOPX), 16'd0);
    check("mid_rst_steps", 16'(STEPS_REMAINING), 16'd0);
    check("mid_rst_error", 16'(ERROR), 16'd0);
    check("mid_rst_done", 16'(DONE), 16'd0);
    check("mid_rst_bphit", 16'(BP_HIT), 16'd0);
    check("mid_rst_ready", 16'(CMD_READY), 16'd1);
    check("mid_rst_state", 16'(dbg_state), 16'(ST_RUN));
    STOPPED = 1'b0;
    tick();
    RESETN = 1'b1;
    tick();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
